// File: rtl/sha_block_ctrl.sv
// SHA-256 block sequencing controller: drives message-schedule load, round counter and
// H-register accumulate strobes. Define SHA_DOUBLE_HASH_EN for a second single-block pass.
module sha_block_ctrl #(
   parameter int ROUNDS = 64,
   parameter int CNT_W  = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       num_blocks,
   input  logic             abort,
   input  logic             msg_valid,
   output logic             msg_ready,
   output logic             load_w,
   output logic [1:0]       block,
   output logic             round_en,
   output logic [CNT_W-1:0] round,
   output logic             acc_en,
   output logic             busy,
   output logic             done,
   output logic             digest_valid,
   output logic             err
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_INIT = 3'd1;
   localparam logic [2:0] S_WAIT = 3'd2;
   localparam logic [2:0] S_RND  = 3'd3;
   localparam logic [2:0] S_ACC  = 3'd4;
   localparam logic [2:0] S_DONE = 3'd5;

   localparam logic [CNT_W-1:0] LAST = CNT_W'(ROUNDS - 1);

   logic [2:0]       state, nstate;
   logic [1:0]       idx, nb_q, block_q;
   logic [CNT_W-1:0] round_q;
   logic             dv_q, err_q;
   logic             start_ok, last_blk, kill;
`ifdef SHA_DOUBLE_HASH_EN
   logic             pass2;
`endif

   assign start_ok = start & ((num_blocks == 2'd1) | (num_blocks == 2'd2));
   assign kill     = abort & (state != S_IDLE);

`ifdef SHA_DOUBLE_HASH_EN
   // the second pass always hashes exactly one block (the padded first digest)
   assign last_blk = pass2 | (idx >= nb_q);
`else
   assign last_blk = (idx >= nb_q);
`endif

   always_comb begin
      nstate = state;
      case (state)
         S_IDLE: if (start_ok) nstate = S_INIT;
         S_INIT: nstate = S_WAIT;
         S_WAIT: if (msg_valid) nstate = S_RND;
         S_RND:  if (round_q == LAST) nstate = S_ACC;
         S_ACC: begin
            if (!last_blk) nstate = S_WAIT;
`ifdef SHA_DOUBLE_HASH_EN
            else if (!pass2) nstate = S_INIT;
`endif
            else nstate = S_DONE;
         end
         S_DONE: nstate = S_IDLE;
         default: nstate = S_IDLE;
      endcase
      if (kill) nstate = S_IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         idx     <= 2'd1;
         nb_q    <= 2'd1;
         block_q <= 2'd0;
         round_q <= '0;
         dv_q    <= 1'b0;
         err_q   <= 1'b0;
`ifdef SHA_DOUBLE_HASH_EN
         pass2   <= 1'b0;
`endif
      end else begin
         state <= nstate;
         err_q <= (state == S_IDLE) & start & ~start_ok;
         if (kill) begin
            dv_q <= 1'b0;
         end else begin
            case (state)
               S_IDLE: if (start_ok) begin
                  nb_q    <= num_blocks;
                  idx     <= 2'd1;
                  dv_q    <= 1'b0;
                  block_q <= 2'd0;
`ifdef SHA_DOUBLE_HASH_EN
                  pass2   <= 1'b0;
`endif
               end
               S_INIT: block_q <= idx;
               S_WAIT: if (msg_valid) round_q <= '0;
               S_RND:  if (round_q != LAST) round_q <= round_q + 1'b1;
               S_ACC: begin
                  if (!last_blk) begin
                     idx     <= idx + 2'd1;
                     block_q <= idx + 2'd1;
                  end
`ifdef SHA_DOUBLE_HASH_EN
                  else if (!pass2) begin
                     pass2   <= 1'b1;
                     idx     <= 2'd1;
                     block_q <= 2'd0;
                  end
`endif
                  else begin
                     dv_q <= 1'b1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   // strobes are masked by abort so a cancelled cycle never reaches the datapath
   assign busy         = (state != S_IDLE);
   assign msg_ready    = (state == S_WAIT) & ~abort;
   assign load_w       = msg_ready & msg_valid;
   assign round_en     = (state == S_RND) & ~abort;
   assign acc_en       = (state == S_ACC) & ~abort;
   assign done         = (state == S_DONE) & ~abort;
   assign err          = err_q;
   assign block        = block_q;
   assign round        = round_q;
   assign digest_valid = dv_q;

endmodule

// File: tb/tb_sha_block_ctrl.sv
// Scoreboard bench for sha_block_ctrl: a job-level timeline model queues expected
// strobe events; a negedge monitor pops and compares them.
module tb_sha_block_ctrl;

   localparam int ROUNDS = 64;
   localparam int CNT_W  = 6;
`ifdef SHA_DOUBLE_HASH_EN
   localparam bit DBL = 1'b1;
`else
   localparam bit DBL = 1'b0;
`endif

   localparam int K_INIT = 0, K_RDY = 1, K_LOAD = 2, K_ROUND = 3, K_ACC = 4, K_DONE = 5, K_ERR = 6;

   typedef struct { int kind; int cyc; int data; } ev_t;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             start = 1'b0;
   logic [1:0]       num_blocks = 2'd0;
   logic             abort = 1'b0;
   logic             msg_valid = 1'b0;
   logic             msg_ready, load_w, round_en, acc_en, busy, done, digest_valid, err;
   logic [1:0]       block;
   logic [CNT_W-1:0] round;

   ev_t exp_q[$];
   int  cyc = 0;
   int  n_tests = 0;
   int  n_fail = 0;
   int  last_done = -1;
   bit  dv_exp = 1'b0;

   sha_block_ctrl #(.ROUNDS(ROUNDS), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .num_blocks(num_blocks), .abort(abort),
      .msg_valid(msg_valid), .msg_ready(msg_ready), .load_w(load_w), .block(block),
      .round_en(round_en), .round(round), .acc_en(acc_en), .busy(busy), .done(done),
      .digest_valid(digest_valid), .err(err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic string kname(int k);
      case (k)
         K_INIT: return "init";  K_RDY: return "ready"; K_LOAD: return "load_w";
         K_ROUND: return "round"; K_ACC: return "acc_en"; K_DONE: return "done";
         default: return "err";
      endcase
   endfunction

   task automatic fail_msg(string s);
      n_fail++;
      if (n_fail <= 20) $display("FAIL %s", s);
   endtask

   task automatic check(string name, int act, int req);
      n_tests++;
      if (act != req) fail_msg($sformatf("%s: got %0d, required %0d", name, act, req));
   endtask

   task automatic mon(int kind, int data);
      ev_t e;
      n_tests++;
      if (exp_q.size() == 0) begin
         fail_msg($sformatf("unexpected %s at cycle %0d data %0d, required no event", kname(kind), cyc, data));
      end else begin
         e = exp_q.pop_front();
         if (e.kind != kind || e.cyc != cyc || e.data != data)
            fail_msg($sformatf("event: got %s@%0d data %0d, required %s@%0d data %0d",
                               kname(kind), cyc, data, kname(e.kind), e.cyc, e.data));
      end
   endtask

   always @(negedge clk) if (rst_n) begin
      if (busy && block == 2'd0) mon(K_INIT, 0);
      if (msg_ready)             mon(K_RDY, int'(block));
      if (load_w)                mon(K_LOAD, int'(block));
      if (round_en)              mon(K_ROUND, int'(round));
      if (acc_en)                mon(K_ACC, int'(block));
      if (done) begin            mon(K_DONE, int'(digest_valid)); last_done = cyc; end
      if (err)                   mon(K_ERR, int'(busy));
   end

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic check_reset_outputs(string name);
      check(name, int'({msg_ready, load_w, block, round_en, round, acc_en, busy, done, digest_valid, err}), 0);
   endtask

   // cut_round >= 0 stops the job at that round of the first block, by abort or by reset
   task automatic run_job(input int nb, input int st0, input int st1, input int cut_round,
                          input bit use_rst, output int c0);
      ev_t loc[$];
      int  ws_q[$], tr_q[$];
      int  t, cut, end_c, k, s, tr, first_tr;
      bit  in_win, is_tr;
      c0 = cyc; t = c0 + 1; k = 0; first_tr = -1; cut = 32'h3fff_ffff;
      for (int p = 0; p < (DBL ? 2 : 1); p++) begin
         loc.push_back('{K_INIT, t, 0}); t++;
         for (int b = 1; b <= ((p == 0) ? nb : 1); b++) begin
            s  = (k == 0) ? st0 : ((k == 1) ? st1 : 0);
            tr = t + s;
            for (int c = t; c <= tr; c++) loc.push_back('{K_RDY, c, b});
            loc.push_back('{K_LOAD, tr, b});
            for (int r = 0; r < ROUNDS; r++) loc.push_back('{K_ROUND, tr + 1 + r, r});
            loc.push_back('{K_ACC, tr + ROUNDS + 1, b});
            ws_q.push_back(t); tr_q.push_back(tr);
            if (first_tr < 0) first_tr = tr;
            t = tr + ROUNDS + 2; k++;
         end
      end
      loc.push_back('{K_DONE, t, 1});
      if (cut_round >= 0) cut = first_tr + 1 + cut_round;
      foreach (loc[i]) if (loc[i].cyc < cut) exp_q.push_back(loc[i]);
      end_c = (cut < t) ? cut : t;

      for (int c = c0; c <= end_c; c++) begin
         start = (c == c0);
         num_blocks = 2'(nb);
         if (c != c0 && c != cut && $urandom_range(7) == 0) begin
            start = 1'b1; num_blocks = 2'($urandom_range(3));
         end
         in_win = 1'b0; is_tr = 1'b0;
         foreach (ws_q[i]) if (c >= ws_q[i] && c <= tr_q[i]) begin in_win = 1'b1; is_tr = (c == tr_q[i]); end
         msg_valid = in_win ? is_tr : 1'($urandom_range(1));
         abort = (c == cut) && !use_rst;
         if (c == cut && use_rst) begin
            #1 rst_n = 1'b0;
            #1 check_reset_outputs("async reset values");
            #4 rst_n = 1'b1;
         end
         step();
      end
      start = 1'b0; abort = 1'b0;
      check("idle after job", int'(busy), 0);
      repeat (3) begin msg_valid = 1'($urandom_range(1)); step(); end
      dv_exp = (cut_round < 0);
      check("digest_valid after job", int'(digest_valid), int'(dv_exp));
      check("scoreboard drained", exp_q.size(), 0);
   endtask

   task automatic err_job(input int nb);
      exp_q.push_back('{K_ERR, cyc + 1, 0});
      start = 1'b1; num_blocks = 2'(nb);
      step();
      start = 1'b0;
      repeat (2) step();
      check("busy after rejected start", int'(busy), 0);
      check("digest_valid after reject", int'(digest_valid), int'(dv_exp));
      check("err drained", exp_q.size(), 0);
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int c0;
      repeat (2) step();
      check_reset_outputs("reset values");
      rst_n = 1'b1;
      step();

      run_job(1, 0, 0, -1, 1'b0, c0);
      check("done latency 1 block", last_done - c0, DBL ? 135 : 68);
      run_job(2, 0, 10, -1, 1'b0, c0);
      check("done latency 2 blocks stall 10", last_done - c0, DBL ? 211 : 144);
      err_job(0);
      err_job(3);
      run_job(1, 0, 0, 30, 1'b0, c0);
      run_job(1, 2, 0, -1, 1'b0, c0);
      err_job(3);
      run_job(2, 1, 0, 20, 1'b1, c0);
      check("digest_valid after mid-job reset", int'(digest_valid), 0);
      run_job(2, 0, 0, -1, 1'b0, c0);
      check("done latency 2 blocks", last_done - c0, DBL ? 201 : 134);

      for (int j = 0; j < 8; j++) begin
         if ($urandom_range(4) == 0) err_job($urandom_range(1) ? 3 : 0);
         run_job($urandom_range(1, 2), $urandom_range(4), $urandom_range(4),
                 ($urandom_range(3) == 0) ? $urandom_range(ROUNDS - 1) : -1, 1'b0, c0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
